icache_refill: RTL and testbench
================================

# icache_refill

Line-refill engine between the instruction cache and the 32-bit main-memory read bus. On a cache miss it fetches one 64-byte line as 16 sequential word reads, assembles the words into a 512-bit line, and presents the line to the cache with a one-cycle ready pulse. It supports pipelined, in-order bus reads with a bounded number of reads outstanding.

## Interface
- MAX_OUT, 16, maximum reads outstanding on the bus (legal 1..16)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  miss request from icache (its mem_addr_valid); must be 0/1 at top level
- req_addr  in  32  miss address from icache (its mem_addr)
- line_ready  out  1  one-cycle pulse: line_data/line_addr valid (to icache mem_data_ready)
- line_data  out  512  assembled line, word i at bits [32i+31:32i]
- line_addr  out  32  line base address {req_addr[31:6], 6'b0} of current/last fill
- bus_rd_valid  out  1  read request valid
- bus_rd_addr  out  32  read word address, always 4-byte aligned
- bus_rd_ready  in  1  bus accepts request when valid & ready
- bus_rsp_valid  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance
- bus_rsp_data  in  32  read data

## Operation
- States: IDLE, FILL, DONE.
- IDLE: bus_rd_valid=0, line_ready=0. On an edge with req_valid=1: latch line_addr={req_addr[31:6],6'b0}, clear issue_cnt and rsp_cnt (5-bit, 0..16), go to FILL. bus_rsp_valid is ignored.
- FILL, issue side: bus_rd_valid=1 when issue_cnt<16 and (issue_cnt−rsp_cnt)<MAX_OUT. bus_rd_addr=line_addr+4·issue_cnt, giving word offsets 0..15 in order. No wrap; the low six bits go 0x00..0x3C. issue_cnt increments on valid&ready.
- FILL, response side: on bus_rsp_valid with rsp_cnt<issue_cnt, write bus_rsp_data to word rsp_cnt of line_data and increment rsp_cnt. A response with rsp_cnt==issue_cnt (unsolicited) is dropped and changes no state.
- When the response making rsp_cnt=16 is captured, go to DONE.
- DONE: line_ready=1 for exactly one cycle, then go to IDLE unconditionally.
- Issue and capture in the same cycle are both performed.
- req_valid and req_addr are ignored outside IDLE.
- A fill is never cancelled. If the cache's request changes mid-fill, the fill completes and pulses line_ready with the original line_addr; the cache discards it on address mismatch. A new miss is taken from IDLE afterwards.
- line_data and line_addr hold their values from DONE until overwritten by the next fill. line_addr updates on IDLE→FILL; word 0 updates at the first capture.

## Timing
- Reset (rst_n=0, asynchronous) gives state IDLE and zeroes the counters. Every output resets to 0: line_ready, line_data, line_addr, bus_rd_valid, bus_rd_addr.
- Reset mid-fill abandons the fill. Responses to reads issued before reset arrive in IDLE and are ignored.
- Zero-wait bus (ready=1, response 1 cycle after accept, MAX_OUT≥2):
  - cycle 0: req_valid=1 sampled.
  - cycles 1–16: addresses issued.
  - cycles 2–17: responses.
  - cycle 18: line_ready=1.
  - cycle 19: IDLE.
  - Earliest next request sample: cycle 19.
- MAX_OUT=1, 1-cycle response: one issue every 2 cycles; line_ready in cycle 33.
- Bus stalls (ready=0 or late responses) only stretch FILL. There is no timeout.

## Test plan
- **Zero-wait fill:** req_addr=0x0000_1234, memory word at addr A = A^0xA5A5_A5A5, ready=1, latency 1.
  - bus_rd_addr runs 0x1200..0x123C in cycles 1–16.
  - line_ready is high only in cycle 18.
  - line_addr=0x1200.
  - line_data word i = (0x1200+4i)^0xA5A5_A5A5.
- **Backpressure and outstanding limit:** MAX_OUT=4, ready toggling 1/0, response latency 5.
  - Never more than 4 reads outstanding.
  - bus_rd_addr holds stable while valid&!ready.
  - Line contents are correct.
- **Request dropped mid-fill:** req_valid goes 1→0 in cycle 5, req_addr changes.
  - Fill still completes.
  - line_ready pulses with the original line_addr.
  - The next fill starts only from IDLE, on a later req_valid=1.
- **Reset mid-fill:** rst_n=0 after 7 words accepted.
  - All outputs read 0 immediately, without waiting for an edge.
  - After release, the 7 pending responses are ignored.
  - A new request to 0x8000_0040 fills correctly from word 0.
- **Back-to-back misses:** req_valid held at 1 through DONE, second address 0x40 higher.
  - Second IDLE→FILL occurs at the cycle-19 edge.
  - line_data from the first fill holds until its word 0 is overwritten.
- **Unsolicited response:** bus_rsp_valid pulsed in IDLE, and in FILL with rsp_cnt==issue_cnt.
  - No change to line_data, line_addr or the counters.

Source files
------------

// File: rtl/icache_refill.sv
// icache_refill: fetches one 64-byte instruction-cache line as 16 in-order
// 32-bit bus reads, with a bounded number of reads in flight, assembles the
// words into a 512-bit line and pulses line_ready for one cycle.
// All outputs come straight from flops; their next values are computed from
// the next-state/next-counter logic so bus-side timing matches a decoded FSM.
module icache_refill #(
    parameter int MAX_OUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         line_ready,
    output logic [511:0] line_data,
    output logic [31:0]  line_addr,
    output logic         bus_rd_valid,
    output logic [31:0]  bus_rd_addr,
    input  logic         bus_rd_ready,
    input  logic         bus_rsp_valid,
    input  logic [31:0]  bus_rsp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] WORDS     = 5'd16;
    localparam logic [4:0] MAX_OUT_C = 5'(MAX_OUT);

    state_t        state_r;
    state_t        state_s;
    logic [4:0]    issue_cnt_r;
    logic [4:0]    issue_cnt_s;
    logic [4:0]    rsp_cnt_r;
    logic [4:0]    rsp_cnt_s;
    logic [31:0]   line_addr_r;
    logic [31:0]   line_addr_s;
    logic [511:0]  line_data_r;
    logic          start_s;
    logic          issue_s;
    logic          capture_s;
    logic          rd_valid_r;
    logic          rd_valid_s;
    logic [31:0]   rd_addr_r;
    logic [31:0]   rd_addr_s;
    logic          line_ready_r;
    logic          line_ready_s;
    logic          unused_addr_bits_s;

    // Only the line-aligned part of the miss address matters.
    assign unused_addr_bits_s = ^req_addr[5:0];

    // Handshake events: new miss taken, read accepted, in-order response captured.
    // A response with nothing outstanding is unsolicited and is dropped.
    always_comb begin
        start_s   = (state_r == IDLE) && req_valid;
        issue_s   = rd_valid_r && bus_rd_ready;
        capture_s = (state_r == FILL) && bus_rsp_valid && (rsp_cnt_r < issue_cnt_r);
    end

    // Next values of the counters and line base address.
    always_comb begin
        issue_cnt_s = issue_cnt_r;
        rsp_cnt_s   = rsp_cnt_r;
        line_addr_s = line_addr_r;
        if (start_s) begin
            issue_cnt_s = 5'd0;
            rsp_cnt_s   = 5'd0;
            line_addr_s = {req_addr[31:6], 6'b000000};
        end else begin
            if (issue_s) begin
                issue_cnt_s = issue_cnt_r + 5'd1;
            end else begin
                issue_cnt_s = issue_cnt_r;
            end
            if (capture_s) begin
                rsp_cnt_s = rsp_cnt_r + 5'd1;
            end else begin
                rsp_cnt_s = rsp_cnt_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: the capture of word 15 completes the fill; DONE lasts one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (capture_s && (rsp_cnt_r == 5'd15)) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs for the coming cycle: issue while words remain and the
    // in-flight window has room; the address is zero whenever not requesting.
    always_comb begin
        rd_valid_s   = 1'b0;
        rd_addr_s    = 32'd0;
        line_ready_s = 1'b0;
        if ((state_s == FILL) && (issue_cnt_s < WORDS) &&
            ((issue_cnt_s - rsp_cnt_s) < MAX_OUT_C)) begin
            rd_valid_s = 1'b1;
            rd_addr_s  = line_addr_s + {25'd0, issue_cnt_s, 2'b00};
        end else begin
            rd_valid_s = 1'b0;
            rd_addr_s  = 32'd0;
        end
        if (state_s == DONE) begin
            line_ready_s = 1'b1;
        end else begin
            line_ready_s = 1'b0;
        end
    end

    // Counters, line base address and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_r  <= 5'd0;
            rsp_cnt_r    <= 5'd0;
            line_addr_r  <= 32'd0;
            rd_valid_r   <= 1'b0;
            rd_addr_r    <= 32'd0;
            line_ready_r <= 1'b0;
        end else begin
            issue_cnt_r  <= issue_cnt_s;
            rsp_cnt_r    <= rsp_cnt_s;
            line_addr_r  <= line_addr_s;
            rd_valid_r   <= rd_valid_s;
            rd_addr_r    <= rd_addr_s;
            line_ready_r <= line_ready_s;
        end
    end

    // Line assembly: each captured response lands in word rsp_cnt; other
    // words keep the previous line until they are overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_data_r <= 512'd0;
        end else if (capture_s) begin
            line_data_r[{rsp_cnt_r[3:0], 5'd0} +: 32] <= bus_rsp_data;
        end else begin
            line_data_r <= line_data_r;
        end
    end

    assign line_ready   = line_ready_r;
    assign line_data    = line_data_r;
    assign line_addr    = line_addr_r;
    assign bus_rd_valid = rd_valid_r;
    assign bus_rd_addr  = rd_addr_r;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: an in-order bus model with configurable latency and
// ready pattern, plus scoreboards of expected read addresses and lines.
module tb_icache_refill;

    localparam int MAX_OUT = 4;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         line_ready;
    logic [511:0] line_data;
    logic [31:0]  line_addr;
    logic         bus_rd_valid;
    logic [31:0]  bus_rd_addr;
    logic         bus_rd_ready;
    logic         bus_rsp_valid;
    logic [31:0]  bus_rsp_data;

    icache_refill #(.MAX_OUT(MAX_OUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .line_ready   (line_ready),
        .line_data    (line_data),
        .line_addr    (line_addr),
        .bus_rd_valid (bus_rd_valid),
        .bus_rd_addr  (bus_rd_addr),
        .bus_rd_ready (bus_rd_ready),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_data (bus_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend_q[$];
    logic [31:0]  exp_rd_q[$];
    logic [31:0]  exp_la_q[$];
    logic [511:0] exp_ld_q[$];
    int           iss_cyc_q[$];
    int           rdy_cyc_q[$];

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           lat     = 1;
    int           rdy_toggle = 0;
    int           rdy_hold = 0;
    int           acc_cnt = 0;
    int           max_seen = 0;
    logic         inj_rsp = 1'b0;
    logic [31:0]  inj_data = 32'd0;
    logic         stall_prev = 1'b0;
    logic [31:0]  stall_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic logic [511:0] exp_line(input logic [31:0] base);
        logic [511:0] d;
        d = 512'd0;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = mem_word(base + 32'(4*i));
        return d;
    endfunction

    // Pushes the 16 expected read addresses and the expected line for a miss.
    task automatic expect_fill(input logic [31:0] req);
        logic [31:0] base;
        base = {req[31:6], 6'b000000};
        for (int i = 0; i < 16; i++) exp_rd_q.push_back(base + 32'(4*i));
        exp_la_q.push_back(base);
        exp_ld_q.push_back(exp_line(base));
    endtask

    // One bus cycle: drive response/ready, sample outputs at negedge, score.
    task automatic tick();
        pend_t       p;
        int          delivered;
        logic [31:0] e;
        delivered = 0;
        if (inj_rsp) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_data  = inj_data;
            inj_rsp       = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            bus_rsp_valid = 1'b1;
            bus_rsp_data  = mem_word(p.addr);
            delivered     = 1;
        end else begin
            bus_rsp_valid = 1'b0;
            bus_rsp_data  = 32'd0;
        end
        if (rdy_hold > 0) begin
            bus_rd_ready = 1'b0;
            rdy_hold--;
        end else if (rdy_toggle != 0) begin
            bus_rd_ready = (cyc % 2 == 0);
        end else begin
            bus_rd_ready = 1'b1;
        end
        @(negedge clk);
        if (pend_q.size() + delivered > max_seen) max_seen = pend_q.size() + delivered;
        if (bus_rd_valid) begin
            n_tests++;
            if (pend_q.size() + delivered >= MAX_OUT) begin
                n_fail++;
                $display("FAIL outstanding: %0d in flight while requesting, limit %0d", pend_q.size() + delivered, MAX_OUT);
            end
        end
        if (stall_prev) begin
            n_tests++;
            if (bus_rd_valid !== 1'b1 || bus_rd_addr !== stall_addr) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b addr=0x%08h, required valid=1 addr=0x%08h", bus_rd_valid, bus_rd_addr, stall_addr);
            end
        end
        stall_prev = bus_rd_valid && !bus_rd_ready;
        stall_addr = bus_rd_addr;
        if (bus_rd_valid && bus_rd_ready) begin
            n_tests++;
            if (exp_rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_addr: unexpected read at 0x%08h, required none", bus_rd_addr);
            end else begin
                e = exp_rd_q.pop_front();
                if (bus_rd_addr !== e) begin
                    n_fail++;
                    $display("FAIL rd_addr: got 0x%08h, required 0x%08h", bus_rd_addr, e);
                end
            end
            p.addr = bus_rd_addr;
            p.due  = cyc + lat;
            pend_q.push_back(p);
            iss_cyc_q.push_back(cyc);
            acc_cnt++;
        end
        if (line_ready) begin
            rdy_cyc_q.push_back(cyc);
            n_tests++;
            if (exp_la_q.size() == 0) begin
                n_fail++;
                $display("FAIL line_ready: unexpected pulse with line_addr=0x%08h", line_addr);
            end else begin
                e = exp_la_q.pop_front();
                if (line_addr !== e || line_data !== exp_ld_q[0]) begin
                    n_fail++;
                    $display("FAIL line: addr 0x%08h data %h, required addr 0x%08h data %h", line_addr, line_data, e, exp_ld_q[0]);
                end
                void'(exp_ld_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_ready(input int budget);
        int n0;
        n0 = rdy_cyc_q.size();
        for (int k = 0; k < budget && rdy_cyc_q.size() == n0; k++) tick();
        n_tests++;
        if (rdy_cyc_q.size() == n0) begin
            n_fail++;
            $display("FAIL line_ready_timeout: no pulse within %0d cycles, required one", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0;
        bus_rd_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'd0;
        #2;
        n_tests++;
        if (line_ready !== 1'b0 || line_data !== 512'd0 || line_addr !== 32'd0 ||
            bus_rd_valid !== 1'b0 || bus_rd_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b addr=0x%08h rv=%b ra=0x%08h, required all 0", line_ready, line_addr, bus_rd_valid, bus_rd_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(); tick();
        n_tests++;
        if (bus_rd_valid !== 1'b0 || line_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rv=%b rdy=%b, required 0 0", bus_rd_valid, line_ready);
        end
    endtask

    task automatic test_zero_wait();
        int c0;
        int first;
        int last;
        lat = 1; rdy_toggle = 0;
        iss_cyc_q.delete(); rdy_cyc_q.delete();
        expect_fill(32'h0000_1234);
        req_valid = 1'b1; req_addr = 32'h0000_1234;
        c0 = cyc;
        tick();
        req_valid = 1'b0; req_addr = 32'd0;
        run_to(c0 + 19);
        n_tests++;
        if (bus_rd_valid !== 1'b0 || line_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_idle19: rv=%b rdy=%b, required 0 0", bus_rd_valid, line_ready);
        end
        run_to(c0 + 22);
        first = (iss_cyc_q.size() > 0) ? iss_cyc_q[0] - c0 : -1;
        last  = (iss_cyc_q.size() > 0) ? iss_cyc_q[iss_cyc_q.size()-1] - c0 : -1;
        n_tests++;
        if (iss_cyc_q.size() != 16 || first != 1 || last != 16) begin
            n_fail++;
            $display("FAIL zw_issue_cycles: %0d reads cycles %0d..%0d, required 16 reads cycles 1..16", iss_cyc_q.size(), first, last);
        end
        first = (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - c0 : -1;
        n_tests++;
        if (rdy_cyc_q.size() != 1 || first != 18) begin
            n_fail++;
            $display("FAIL zw_ready_cycle: %0d pulses first at %0d, required 1 pulse at 18", rdy_cyc_q.size(), first);
        end
    endtask

    task automatic test_backpressure(input int latency, input int need_max);
        lat = latency; rdy_toggle = 1; max_seen = 0;
        expect_fill(32'h0000_5A9C);
        req_valid = 1'b1; req_addr = 32'h0000_5A9C;
        tick();
        req_valid = 1'b0;
        wait_ready(300);
        rdy_toggle = 0;
        tick();
        n_tests++;
        if (exp_rd_q.size() != 0 || max_seen > MAX_OUT || max_seen < need_max) begin
            n_fail++;
            $display("FAIL bp_window: %0d reads left, peak %0d in flight, required 0 left peak %0d..%0d", exp_rd_q.size(), max_seen, need_max, MAX_OUT);
        end
    endtask

    task automatic test_req_drop();
        int c0;
        lat = 2; rdy_toggle = 0;
        expect_fill(32'h0000_2010);
        req_valid = 1'b1; req_addr = 32'h0000_2010;
        c0 = cyc;
        tick();
        run_to(c0 + 5);
        req_valid = 1'b0; req_addr = 32'h0000_9000;
        wait_ready(60);
        repeat (5) tick();
        n_tests++;
        if (bus_rd_valid !== 1'b0 || line_addr !== 32'h0000_2000 || exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drop_idle: rv=%b line_addr=0x%08h, required rv=0 line_addr=0x00002000", bus_rd_valid, line_addr);
        end
    endtask

    task automatic test_unsolicited();
        lat = 2; rdy_toggle = 0;
        inj_rsp = 1'b1; inj_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        n_tests++;
        if (line_data !== exp_line(32'h0000_2000) || line_addr !== 32'h0000_2000 || bus_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unsol_idle: line_addr=0x%08h rv=%b word0=0x%08h, required 0x00002000 0 0x%08h", line_addr, bus_rd_valid, line_data[31:0], mem_word(32'h0000_2000));
        end
        expect_fill(32'h0000_4400);
        req_valid = 1'b1; req_addr = 32'h0000_4400;
        tick();
        req_valid = 1'b0;
        inj_rsp = 1'b1; inj_data = 32'hDEAD_BEEF; rdy_hold = 1;
        tick();
        tick();
        n_tests++;
        if (line_data[31:0] !== mem_word(32'h0000_2000)) begin
            n_fail++;
            $display("FAIL unsol_fill: word0=0x%08h, required 0x%08h", line_data[31:0], mem_word(32'h0000_2000));
        end
        wait_ready(60);
    endtask

    task automatic test_back_to_back();
        int           c0;
        int           second;
        logic [511:0] l1;
        lat = 1; rdy_toggle = 0;
        iss_cyc_q.delete(); rdy_cyc_q.delete();
        l1 = exp_line(32'h0000_3000);
        expect_fill(32'h0000_3000);
        expect_fill(32'h0000_3040);
        req_valid = 1'b1; req_addr = 32'h0000_3000;
        c0 = cyc;
        tick();
        req_addr = 32'h0000_3040;
        for (int k = 19; k <= 21; k++) begin
            run_to(c0 + k);
            n_tests++;
            if (line_data !== l1) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: word0=0x%08h, required 0x%08h", k, line_data[31:0], l1[31:0]);
            end
        end
        req_valid = 1'b0;
        run_to(c0 + 22);
        n_tests++;
        if (line_data[31:0] !== mem_word(32'h0000_3040) || line_data[511:32] !== l1[511:32] ||
            line_addr !== 32'h0000_3040) begin
            n_fail++;
            $display("FAIL b2b_word0: word0=0x%08h addr=0x%08h, required 0x%08h 0x00003040", line_data[31:0], line_addr, mem_word(32'h0000_3040));
        end
        wait_ready(40);
        second = (iss_cyc_q.size() > 16) ? iss_cyc_q[16] - c0 : -1;
        n_tests++;
        if (iss_cyc_q.size() != 32 || second != 20) begin
            n_fail++;
            $display("FAIL b2b_restart: %0d reads second fill from cycle %0d, required 32 from 20", iss_cyc_q.size(), second);
        end
    endtask

    task automatic test_reset_mid_fill();
        int acc0;
        lat = 3; rdy_toggle = 0;
        expect_fill(32'h0000_7000);
        acc0 = acc_cnt;
        req_valid = 1'b1; req_addr = 32'h0000_7000;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 40 && acc_cnt - acc0 < 7; k++) tick();
        n_tests++;
        if (acc_cnt - acc0 != 7) begin
            n_fail++;
            $display("FAIL rst_accepts: %0d reads accepted, required 7", acc_cnt - acc0);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (line_ready !== 1'b0 || line_data !== 512'd0 || line_addr !== 32'd0 ||
            bus_rd_valid !== 1'b0 || bus_rd_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async: rdy=%b addr=0x%08h rv=%b ra=0x%08h, required all 0", line_ready, line_addr, bus_rd_valid, bus_rd_addr);
        end
        exp_rd_q.delete(); exp_la_q.delete(); exp_ld_q.delete();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20 && pend_q.size() > 0; k++) tick();
        tick(); tick();
        n_tests++;
        if (line_data !== 512'd0 || line_addr !== 32'd0 || bus_rd_valid !== 1'b0 || pend_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_stale: word0=0x%08h addr=0x%08h rv=%b, required 0 0 0", line_data[31:0], line_addr, bus_rd_valid);
        end
        expect_fill(32'h8000_0040);
        req_valid = 1'b1; req_addr = 32'h8000_0040;
        tick();
        req_valid = 1'b0;
        wait_ready(60);
        n_tests++;
        if (exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_refill: %0d reads missing, required 0", exp_rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure(5, 1);
        test_backpressure(9, MAX_OUT);
        test_req_drop();
        test_unsolicited();
        test_back_to_back();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
